smem_text_writer: RTL and testbench
===================================

Name: smem_text_writer

Overview:
- Upstream producer for the text-mode screen memory consumed by the VGA display driver.
- Accepts a stream of character and control commands over a valid/ready handshake and maintains a text cursor.
- Drives the write port of the dual-port screen memory. The display driver keeps reading through the other port.
- Provides a full-screen clear sweep, so a writable screen RAM can replace the initialised ROM.

Parameters:
- Nchars, 4, number of distinct character/sprite codes; data width is $clog2(Nchars).
- Ncols, 40, text columns per screen row.
- Nrows, 30, text rows per screen; smem_size = Ncols*Nrows (1200).
- fill_char, 0, charcode written at every location by a clear sweep.

Ports:
- clk  input  1  system clock (50 MHz domain of the display).
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  command present.
- in_ready  output  1  block can accept a command this cycle.
- in_cmd  input  2  00 PUT, 01 NEWLINE, 10 CLEAR, 11 HOME.
- in_char  input  $clog2(Nchars)  charcode for PUT; ignored for other commands.
- smem_wr  output  1  screen memory write enable, one-cycle pulse per write.
- smem_waddr  output  $clog2(Ncols*Nrows)  write address, row-major (row*Ncols+col).
- smem_wdata  output  $clog2(Nchars)  write data.
- cur_col  output  $clog2(Ncols)  current cursor column.
- cur_row  output  $clog2(Nrows)  current cursor row.
- busy  output  1  high while a clear sweep is running.

Behaviour:
- Reset is asynchronous and active-low. While reset_n=0 the outputs hold these values:
  - smem_wr=0, smem_waddr=0, smem_wdata=0
  - cur_col=0, cur_row=0
  - busy=0, in_ready=1
  - FSM in IDLE
- All outputs are registered.
- FSM has two states: IDLE and CLEAR.
  - in_ready = (state==IDLE).
  - busy = (state==CLEAR).
- A command is accepted only on a cycle where in_valid && in_ready.
- PUT accepted in cycle N:
  - Cycle N+1: smem_wr=1, smem_waddr = old row*Ncols + old col, smem_wdata = in_char.
  - The cursor advances in the same cycle N+1.
  - Back-to-back PUTs sustain one write per cycle.
- Cursor advance rules:
  - col<Ncols-1: col+1.
  - col==Ncols-1: col=0 and row+1.
  - Row Nrows-1 followed by a row increment wraps to row 0. There is no scrolling.
- The address is maintained incrementally (+1 per advance, row-start tracking for NEWLINE). No multiplier is used. Address wraps 1199 -> 0 together with the cursor.
- NEWLINE:
  - col=0, row+1 (same row wrap as above).
  - No write. smem_wr stays 0.
  - The cursor update is visible at N+1.
- HOME:
  - col=0, row=0.
  - No write. Visible at N+1.
- CLEAR accepted in cycle N:
  - FSM enters CLEAR at N+1.
  - Cycles N+1 .. N+Ncols*Nrows: smem_wr=1, smem_wdata=fill_char, smem_waddr = 0,1,...,Ncols*Nrows-1 in order.
  - The cycle after the last write: FSM returns to IDLE and in_ready=1. Cursor is 0,0 by then.
- in_valid while in_ready=0 is held by the producer and is not consumed. in_cmd and in_char are don't-care until acceptance.
- smem_wr is 0 on every cycle that carries no write.
- Reset asserted mid-sweep aborts the sweep immediately. The sweep is not resumed after release unless the optional feature is compiled in.
- Memory contents are outside this block; partially cleared contents persist after an abort.

Optional Feature:
- Macro: SMEM_CLEAR_ON_RESET_EN.
- Defined:
  - Reset release enters CLEAR directly instead of IDLE.
  - in_ready=0 and busy=1 from the first clk edge after reset_n rises.
  - The full sweep 0..Ncols*Nrows-1 runs, then the FSM goes to IDLE.
  - Values while reset_n=0 are unchanged, except busy=1 and in_ready=0 during reset.
- Undefined: reset behaviour exactly as in Behaviour.

Test Plan:
All cases use Ncols=40, Nrows=30, Nchars=4.
1. Reset then PUT char 2 -> next cycle smem_wr=1, addr 0, data 2. Cursor becomes col 1, row 0.
2. 41 back-to-back PUTs of char 1 -> 41 consecutive writes at addrs 0..40. Final cursor is col 1, row 1. in_ready is high throughout.
3. PUT x3, then NEWLINE, then PUT char 3 -> the NEWLINE produces no write. The next write is at addr 40 with data 3.
4. Cursor at col 39, row 29, PUT char 1 -> write at addr 1199. Cursor wraps to 0,0; the next PUT writes addr 0.
5. CLEAR with fill_char=0 -> 1200 consecutive writes, addrs 0..1199, data 0. busy=1 for exactly 1200 cycles. in_valid held high during the sweep is not accepted until in_ready returns. Cursor is 0,0 afterwards.
6. Reset pulse at sweep write 500 -> outputs return to reset values asynchronously. No further writes after release, and in_ready=1. With SMEM_CLEAR_ON_RESET_EN defined, a full sweep of 1200 writes starting at addr 0 follows reset release instead.

Source files
------------

// File: rtl/smem_text_writer.sv
// Text-mode screen memory writer: cursor-tracked PUT/NEWLINE/HOME commands plus a full-screen clear sweep.
// Optional macro SMEM_CLEAR_ON_RESET_EN starts a clear sweep automatically on reset release.
module smem_text_writer #(
  parameter int Nchars    = 4,
  parameter int Ncols     = 40,
  parameter int Nrows     = 30,
  parameter int fill_char = 0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [1:0]                       in_cmd,
  input  logic [$clog2(Nchars)-1:0]        in_char,
  output logic                             smem_wr,
  output logic [$clog2(Ncols*Nrows)-1:0]   smem_waddr,
  output logic [$clog2(Nchars)-1:0]        smem_wdata,
  output logic [$clog2(Ncols)-1:0]         cur_col,
  output logic [$clog2(Nrows)-1:0]         cur_row,
  output logic                             busy
);

  localparam int DW   = $clog2(Nchars);
  localparam int AW   = $clog2(Ncols*Nrows);
  localparam int CW   = $clog2(Ncols);
  localparam int RW   = $clog2(Nrows);
  localparam int Size = Ncols * Nrows;

  localparam logic [1:0] CMD_PUT     = 2'b00;
  localparam logic [1:0] CMD_NEWLINE = 2'b01;
  localparam logic [1:0] CMD_CLEAR   = 2'b10;

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

`ifdef SMEM_CLEAR_ON_RESET_EN
  localparam state_t RstState = S_CLEAR;
  localparam logic   RstReady = 1'b0;
`else
  localparam state_t RstState = S_IDLE;
  localparam logic   RstReady = 1'b1;
`endif

  state_t         state_q;
  logic [AW-1:0]  addr_q;
  logic [AW-1:0]  row_base_q;

  logic           last_col_s;
  logic           last_row_s;
  logic [RW-1:0]  row_inc_d;
  logic [AW-1:0]  row_base_inc_d;
  logic [AW-1:0]  addr_inc_d;

  // Next-cursor candidates; the linear address is tracked incrementally instead of row*Ncols+col.
  always_comb begin
    last_col_s     = (cur_col == CW'(Ncols - 1));
    last_row_s     = (cur_row == RW'(Nrows - 1));
    row_inc_d      = last_row_s ? {RW{1'b0}} : cur_row + RW'(1);
    row_base_inc_d = last_row_s ? {AW{1'b0}} : row_base_q + AW'(Ncols);
    addr_inc_d     = (addr_q == AW'(Size - 1)) ? {AW{1'b0}} : addr_q + AW'(1);
  end

  // Command FSM with registered write port, cursor and handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RstState;
      in_ready   <= RstReady;
      busy       <= ~RstReady;
      smem_wr    <= 1'b0;
      smem_waddr <= {AW{1'b0}};
      smem_wdata <= {DW{1'b0}};
      cur_col    <= {CW{1'b0}};
      cur_row    <= {RW{1'b0}};
      addr_q     <= {AW{1'b0}};
      row_base_q <= {AW{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          smem_wr <= 1'b0;
          if (in_valid) begin
            case (in_cmd)
              CMD_PUT: begin
                smem_wr    <= 1'b1;
                smem_waddr <= addr_q;
                smem_wdata <= in_char;
                addr_q     <= addr_inc_d;
                if (last_col_s) begin
                  cur_col    <= {CW{1'b0}};
                  cur_row    <= row_inc_d;
                  row_base_q <= row_base_inc_d;
                end else begin
                  cur_col <= cur_col + CW'(1);
                end
              end
              CMD_NEWLINE: begin
                cur_col    <= {CW{1'b0}};
                cur_row    <= row_inc_d;
                row_base_q <= row_base_inc_d;
                addr_q     <= row_base_inc_d;
              end
              CMD_CLEAR: begin
                // First sweep write is issued straight from the accepting edge.
                state_q    <= S_CLEAR;
                in_ready   <= 1'b0;
                busy       <= 1'b1;
                smem_wr    <= 1'b1;
                smem_waddr <= {AW{1'b0}};
                smem_wdata <= DW'(fill_char);
                cur_col    <= {CW{1'b0}};
                cur_row    <= {RW{1'b0}};
                addr_q     <= {AW{1'b0}};
                row_base_q <= {AW{1'b0}};
              end
              default: begin
                cur_col    <= {CW{1'b0}};
                cur_row    <= {RW{1'b0}};
                addr_q     <= {AW{1'b0}};
                row_base_q <= {AW{1'b0}};
              end
            endcase
          end
        end
        S_CLEAR: begin
          smem_wdata <= DW'(fill_char);
          if (!smem_wr) begin
            // Sweep entered from reset: nothing written yet, start at address 0.
            smem_wr    <= 1'b1;
            smem_waddr <= {AW{1'b0}};
          end else if (smem_waddr == AW'(Size - 1)) begin
            state_q  <= S_IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            smem_wr  <= 1'b0;
          end else begin
            smem_wr    <= 1'b1;
            smem_waddr <= smem_waddr + AW'(1);
          end
        end
        default: begin
          state_q  <= S_IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
          smem_wr  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_smem_text_writer.sv
// Self-checking bench for smem_text_writer: directed steps plus random commands against a queue-based screen model.
module tb_smem_text_writer;

  localparam int NC = 40;
  localparam int NR = 30;
  localparam int SZ = NC * NR;

  localparam logic [1:0] PUT  = 2'b00;
  localparam logic [1:0] NL   = 2'b01;
  localparam logic [1:0] CLR  = 2'b10;
  localparam logic [1:0] HOME = 2'b11;

`ifdef SMEM_CLEAR_ON_RESET_EN
  localparam bit CLR_RST = 1'b1;
`else
  localparam bit CLR_RST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_cmd = 2'b00;
  logic [1:0]  in_char = 2'b00;
  logic        smem_wr;
  logic [10:0] smem_waddr;
  logic [1:0]  smem_wdata;
  logic [5:0]  cur_col;
  logic [4:0]  cur_row;
  logic        busy;

  smem_text_writer #(.Nchars(4), .Ncols(NC), .Nrows(NR), .fill_char(0)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_char(in_char), .smem_wr(smem_wr), .smem_waddr(smem_waddr),
    .smem_wdata(smem_wdata), .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: cursor as a linear screen position, expected writes as a queue popped one per cycle.
  typedef struct {bit sweep; int addr; int data;} wr_t;
  wr_t exp_q[$];
  int  pos;
  bit  m_ready;
  int  n_assert;
  int  n_fail;
  int  busy_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_sweep();
    for (int k = 0; k < SZ; k++) exp_q.push_back('{sweep: 1'b1, addr: k, data: 0});
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_wr"}, smem_wr, 0);
    chk({tag, "_waddr"}, smem_waddr, 0);
    chk({tag, "_wdata"}, smem_wdata, 0);
    chk({tag, "_col"}, cur_col, 0);
    chk({tag, "_row"}, cur_row, 0);
    chk({tag, "_busy"}, busy, CLR_RST);
    chk({tag, "_ready"}, in_ready, !CLR_RST);
  endtask

  task automatic do_reset(input string tag);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check_reset_vals({tag, "_async"});
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals({tag, "_held"});
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    pos     = 0;
    m_ready = !CLR_RST;
    if (CLR_RST) push_sweep();
  endtask

  task automatic cycle(input bit v, input logic [1:0] c, input int ch);
    wr_t e;
    bit  ew;
    bit  es;
    in_valid = v;
    in_cmd   = c;
    in_char  = ch[1:0];
    if (v && m_ready) begin
      case (c)
        PUT: begin
          exp_q.push_back('{sweep: 1'b0, addr: pos, data: ch});
          pos = (pos + 1) % SZ;
        end
        NL:      pos = ((pos / NC + 1) % NR) * NC;
        HOME:    pos = 0;
        default: begin push_sweep(); pos = 0; end
      endcase
    end
    @(posedge clk);
    #1;
    ew = 1'b0;
    es = 1'b0;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ew = 1'b1;
      es = e.sweep;
    end
    m_ready = !es;
    chk("smem_wr", smem_wr, ew);
    if (ew) begin
      chk("smem_waddr", smem_waddr, e.addr);
      chk("smem_wdata", smem_wdata, e.data);
    end
    chk("cur_col", cur_col, pos % NC);
    chk("cur_row", cur_row, pos / NC);
    chk("busy", busy, es);
    chk("in_ready", in_ready, !es);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) cycle(1'b0, PUT, 0);
    repeat (3) cycle(1'b0, PUT, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    #2;
    do_reset("reset");
    drain();

    // Single PUT lands at address 0 and moves the cursor one column.
    cycle(1'b1, PUT, 2);

    // 41 back-to-back PUTs cross into the second row.
    cycle(1'b1, HOME, 0);
    repeat (41) cycle(1'b1, PUT, 1);
    chk("t2_col", cur_col, 1);
    chk("t2_row", cur_row, 1);

    // NEWLINE writes nothing; the following PUT goes to the start of row 1.
    cycle(1'b1, HOME, 0);
    repeat (3) cycle(1'b1, PUT, $urandom_range(0, 3));
    cycle(1'b1, NL, 0);
    cycle(1'b1, PUT, 3);

    // Bottom-right corner write wraps the cursor and address to 0.
    cycle(1'b1, HOME, 0);
    repeat (NR - 1) cycle(1'b1, NL, 0);
    repeat (NC - 1) cycle(1'b1, PUT, $urandom_range(0, 3));
    cycle(1'b1, PUT, 1);
    cycle(1'b1, PUT, 2);

    // Random command stream with idle gaps.
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [1:0] c;
      r = $urandom_range(0, 99);
      c = (r < 80) ? PUT : (r < 96) ? NL : HOME;
      cycle($urandom_range(0, 3) != 0, c, $urandom_range(0, 3));
    end

    // Full clear with in_valid held high throughout the sweep.
    busy_cnt = 0;
    cycle(1'b1, CLR, 0);
    if (busy) busy_cnt++;
    for (int i = 0; i < SZ + 2; i++) begin
      cycle(1'b1, PUT, 2);
      if (busy) busy_cnt++;
    end
    chk("t5_busy_cycles", busy_cnt, SZ);
    cycle(1'b0, PUT, 0);

    // Reset in the middle of a sweep.
    cycle(1'b1, CLR, 0);
    repeat (499) cycle(1'b0, PUT, 0);
    #2;
    do_reset("abort");
    drain();
    repeat (20) cycle(1'b0, PUT, 0);
    cycle(1'b1, PUT, 3);
    cycle(1'b0, PUT, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
